// File: rtl/diag_response_compare.sv
// diag_response_compare: golden compare of skewed systolic column results, deskewed
// into one per-row fault vector for the diagnostic loop chains.

module diag_response_lane #(
    parameter int DW    = 16,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld,
    input  logic [DW-1:0] res,
    input  logic [DW-1:0] gold,
    output logic          a_mv,
    output logic          a_mm
);
    // stage 0 is the compare register; DEPTH further stages realign this column
    logic [DEPTH:0] vld_pipe;
    logic [DEPTH:0] mm_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            mm_pipe  <= '0;
        end else begin
            vld_pipe[0] <= vld;
            mm_pipe[0]  <= (res != gold);
            for (int k = 1; k <= DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                mm_pipe[k]  <= mm_pipe[k-1];
            end
        end
    end

    assign a_mv = vld_pipe[DEPTH];
    assign a_mm = mm_pipe[DEPTH];
endmodule

module diag_response_compare #(
    parameter int DW = 16,
    parameter int N  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          res_valid,
    input  logic [N*DW-1:0]       res_data,
    input  logic [N*DW-1:0]       gold_data,
    input  logic [N-1:0]          col_mask,
    output logic [N-1:0]          fault_col,
    output logic                  fault_valid,
    output logic [$clog2(N)-1:0]  row_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  fault_any,
    output logic                  err_protocol
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [CW-1:0] acc_cnt, emit_cnt;
    logic          done_q, fault_any_q, err_q;
    logic          run, acc_ok, accept, overrun, emit, last_emit, missing, orphan;
    logic [N-1:0]  lane_vld, a_mv, a_mm;

    assign run     = (state == RUN);
    assign acc_ok  = (acc_cnt < CW'(N));
    assign accept  = run & res_valid[0] & acc_ok;
    assign overrun = run & res_valid[0] & ~acc_ok;

    // column 0 carries the row-accept decision; the others only need the session gate
    always_comb begin
        lane_vld    = res_valid & {N{run}};
        lane_vld[0] = accept;
    end

    for (genvar c = 0; c < N; c++) begin : g_lane
        diag_response_lane #(.DW(DW), .DEPTH(N - 1 - c)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .vld   (lane_vld[c]),
            .res   (res_data[c*DW +: DW]),
            .gold  (gold_data[c*DW +: DW]),
            .a_mv  (a_mv[c]),
            .a_mm  (a_mm[c])
        );
    end

    assign emit      = a_mv[0];
    assign last_emit = run & emit & (emit_cnt == CW'(N - 1));
    assign missing   = emit & ~(&a_mv);
    assign orphan    = ~emit & (|a_mv);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_emit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt     <= '0;
            emit_cnt    <= '0;
            done_q      <= 1'b0;
            fault_any_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= last_emit;
            if (!run && start) begin
                acc_cnt     <= '0;
                emit_cnt    <= '0;
                fault_any_q <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (emit) emit_cnt <= emit_cnt + 1'b1;
                if (overrun || missing || orphan) err_q <= 1'b1;
                if (emit && (|fault_col)) fault_any_q <= 1'b1;
            end
        end
    end

    // an absent column response is reported as a fault unless the column is repaired
    assign fault_col    = emit ? (~col_mask & (a_mm | ~a_mv)) : '0;
    assign fault_valid  = emit;
    assign row_idx      = emit_cnt[$clog2(N)-1:0];
    assign busy         = run;
    assign done         = done_q;
    assign fault_any    = fault_any_q;
    assign err_protocol = err_q;
endmodule

// File: tb/tb_diag_response_compare.sv
// Directed and randomized sessions checked against a cycle-indexed model of the
// expected per-row fault stream.

module tb_diag_response_compare;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int T  = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [N-1:0]         res_valid = '0;
    logic [N*DW-1:0]      res_data = '0;
    logic [N*DW-1:0]      gold_data = '0;
    logic [N-1:0]         col_mask = '0;
    logic [N-1:0]         fault_col;
    logic                 fault_valid;
    logic [$clog2(N)-1:0] row_idx;
    logic                 busy, done, fault_any, err_protocol;

    int checks = 0;
    int errors = 0;

    // session description
    int          row_t[N];
    logic [DW-1:0] rv[N][N];
    logic [DW-1:0] gv[N][N];
    bit          drop[N][N];

    diag_response_compare #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
        .res_data(res_data), .gold_data(gold_data), .col_mask(col_mask),
        .fault_col(fault_col), .fault_valid(fault_valid), .row_idx(row_idx),
        .busy(busy), .done(done), .fault_any(fault_any), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".fault_col"}, 32'(fault_col), 0);
        chk({tag, ".fault_valid"}, 32'(fault_valid), 0);
        chk({tag, ".row_idx"}, 32'(row_idx), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".fault_any"}, 32'(fault_any), 0);
        chk({tag, ".err_protocol"}, 32'(err_protocol), 0);
    endtask

    task automatic gen_rows(input bit b2b, input int mm_pct, input int drop_pct);
        int t = 1;
        for (int r = 0; r < N; r++) begin
            row_t[r] = t;
            t += 1 + (b2b ? 0 : int'($urandom_range(0, 2)));
            for (int c = 0; c < N; c++) begin
                rv[r][c] = DW'($urandom);
                gv[r][c] = rv[r][c];
                if (int'($urandom_range(0, 99)) < mm_pct)
                    gv[r][c] = rv[r][c] ^ (DW'(1) << $urandom_range(0, DW - 1));
                drop[r][c] = (c != 0) && (int'($urandom_range(0, 99)) < drop_pct);
            end
        end
    endtask

    // Drives one session starting at relative cycle 0 and checks every cycle.
    // abort_at >= 0 pulls reset in that cycle instead of finishing.
    task automatic run_session(input string name, input bit over_en, input bit stray_start,
                               input int abort_at);
        bit          e_fv[T];
        logic [N-1:0] e_fc[T];
        int          e_ri[T];
        int          fa_at, err_at, e_last, len, t_over;
        e_last = row_t[N-1] + N;
        len    = e_last + 3;
        t_over = row_t[N-1] + 1;
        fa_at  = T + 10;
        err_at = over_en ? t_over + 1 : T + 10;
        for (int k = 0; k < T; k++) begin
            e_fv[k] = 0; e_fc[k] = '0; e_ri[k] = 0;
        end
        for (int r = 0; r < N; r++) begin
            int e = row_t[r] + N;
            e_fv[e] = 1;
            e_ri[e] = r;
            for (int c = 0; c < N; c++) begin
                e_fc[e][c] = !col_mask[c] && ((rv[r][c] != gv[r][c]) || drop[r][c]);
                if (drop[r][c] && e + 1 < err_at) err_at = e + 1;
            end
            if (e_fc[e] != '0 && e + 1 < fa_at) fa_at = e + 1;
        end
        for (int k = 0; k <= len; k++) begin
            start = (k == 0) || (stray_start && k == 3);
            res_valid = '0;
            for (int c = 0; c < N; c++) begin
                res_data[c*DW +: DW]  = DW'($urandom);
                gold_data[c*DW +: DW] = DW'($urandom);
                for (int r = 0; r < N; r++)
                    if (row_t[r] + c == k) begin
                        res_valid[c] = !drop[r][c];
                        res_data[c*DW +: DW]  = rv[r][c];
                        gold_data[c*DW +: DW] = gv[r][c];
                    end
            end
            if (over_en && k == t_over) res_valid[0] = 1'b1;
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero({name, ".abort"});
                start = 1'b0; res_valid = '0;
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            chk({name, ".fault_valid"}, 32'(fault_valid), 32'(e_fv[k]));
            chk({name, ".fault_col"}, 32'(fault_col), 32'(e_fc[k]));
            if (e_fv[k]) chk({name, ".row_idx"}, 32'(row_idx), 32'(e_ri[k]));
            chk({name, ".busy"}, 32'(busy), 32'(k >= 1 && k <= e_last));
            if (k >= 1) begin
                chk({name, ".done"}, 32'(done), 32'(k == e_last + 1));
                chk({name, ".fault_any"}, 32'(fault_any), 32'(k >= fa_at));
                chk({name, ".err_protocol"}, 32'(err_protocol), 32'(k >= err_at));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        res_valid = '0;
    endtask

    initial begin
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        gen_rows(1, 0, 0);
        run_session("all_match", 0, 0, -1);

        gen_rows(1, 0, 0);
        rv[3][5] = 16'h1234; gv[3][5] = 16'h1235;
        run_session("single_mm", 0, 0, -1);

        col_mask = 8'h20;
        run_session("masked", 0, 0, -1);
        col_mask = '0;

        gen_rows(1, 0, 0);
        drop[6][2] = 1;
        run_session("missing", 0, 0, -1);

        // traffic while idle must leave no trace
        for (int k = 0; k < 12; k++) begin
            res_valid = '1;
            res_data = {N{16'hAAAA}};
            gold_data = {N{16'h5555}};
            @(negedge clk);
            chk("idle.busy", 32'(busy), 0);
            chk("idle.fault_valid", 32'(fault_valid), 0);
            @(posedge clk); #1;
        end
        res_valid = '0;

        gen_rows(1, 0, 0);
        run_session("overrun", 1, 0, -1);

        gen_rows(1, 0, 0);
        run_session("abort", 0, 0, 6);
        gen_rows(1, 0, 0);
        run_session("post_abort", 0, 0, -1);

        for (int i = 0; i < 25; i++) begin
            col_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            gen_rows(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 4)));
            run_session("random", bit'($urandom_range(0, 3) == 0),
                        bit'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/diag_response_compare.md
# diag_response_compare

Upstream feeder for the diagnostic loop chains of the 8×8 systolic array under self-test. It takes the skewed partial-sum outputs from the bottom of each PE column and compares each against its golden value. Per-column mismatches are deskewed so that all N fault bits of one array row leave in the same cycle. The result is a per-row fault vector, strobed and indexed, that drives the loop chains' column inputs directly.

## Interface
Parameters:
- DW, 16, data width of one column result / golden word
- N, 8, number of array columns and rows per test session (loop-chain depth)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; opens a test session of N rows
- res_valid  in  N  bit c: column c result valid (column c lags column 0 by c cycles)
- res_data  in  N*DW  column c result in bits [c*DW +: DW]
- gold_data  in  N*DW  golden word for column c, same slice and timing as res_data
- col_mask  in  N  1 = column excluded (already repaired); its fault bit is forced 0
- fault_col  out  N  per-column fault bits for row row_idx; feeds loop-chain inputs col_0..col_N-1
- fault_valid  out  1  fault_col/row_idx qualifier, one cycle per row
- row_idx  out  $clog2(N)  row number of the current fault_col
- busy  out  1  session in progress
- done  out  1  one-cycle pulse when the last row has been emitted
- fault_any  out  1  sticky: any unmasked fault emitted this session
- err_protocol  out  1  sticky: handshake violation this session

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on start. RUN clears the acc_cnt and emit_cnt counters and clears fault_any and err_protocol.
  - RUN→IDLE when emit_cnt reaches N. done pulses for one cycle in the same cycle busy falls.
  - start during RUN is ignored.
- Accept: in RUN, a row is accepted when res_valid[0]=1 and acc_cnt<N, which increments acc_cnt. A res_valid[0] pulse with acc_cnt=N sets err_protocol and is otherwise ignored. All res_valid bits are ignored in IDLE.
- Compare (stage 1, registered): for each column c, mm[c] <= (res_data_c != gold_data_c) and mv[c] <= res_valid[c]. Full DW-bit inequality, no tolerance.
- Deskew: column c's {mv, mm} passes through a delay line of N-1-c registers, so column N-1 has no extra delay. All columns of one row align at the output.
- Emit: when the aligned column-0 valid is set:
  - fault_valid=1 and row_idx=emit_cnt, then emit_cnt increments.
  - fault_col[c] = ~col_mask[c] & (aligned mm[c] | ~aligned mv[c]). A missing column response counts as a fault.
  - A missing response (aligned mv[c]=0 while aligned column-0 valid=1) also sets err_protocol.
  - An aligned mv[c]=1 without an aligned column-0 valid sets err_protocol and emits nothing.
- col_mask is sampled at the emit cycle.
- fault_any <= fault_any | (fault_valid & |fault_col).
- When fault_valid=0, fault_col=0.
- Rows may arrive back-to-back, with one row per cycle and no bubble required.
- Reset, including mid-session: all flops clear, FSM returns to IDLE, and in-flight rows are discarded.

## Timing
- Reset values: fault_col=0, fault_valid=0, row_idx=0, busy=0, done=0, fault_any=0, err_protocol=0.
- start at cycle s: busy=1 from s+1.
- Latency: res_valid[0] for row r at cycle t (column c at t+c) gives fault_valid for row r at t+N. That is 1 compare cycle plus N-1 deskew cycles relative to column 0.
- Last row emitted at cycle e: done=1 and busy=0 at e+1.
- fault_valid and emitted rows stay contiguous with respect to input spacing; any gaps in res_valid[0] are reproduced at the output.

## Test plan
- All match, 8 back-to-back rows with res_valid[0] at t0..t0+7 → fault_valid at t0+8..t0+15, row_idx 0..7, fault_col=0x00. Then done=1 at t0+16, fault_any=0, err_protocol=0.
- Single mismatch: row 3, column 5, res=0x1234 vs gold=0x1235 → only row_idx=3 shows fault_col=0x20 at t0+11. fault_any=1 from t0+12.
- Masked column: col_mask=0x20 with the same stimulus as the single-mismatch case → fault_col=0x00 on all rows and fault_any=0.
- Missing response: res_valid[2] withheld for row 6 → row 6 has fault_col=0x04 and err_protocol=1. All other rows are clean.
- Overrun and idle traffic:
  - res_valid[0] pulses before start → ignored, busy=0.
  - A ninth res_valid[0] in RUN → err_protocol=1, exactly 8 fault_valid pulses.
- Reset mid-session: rst_n low after 4 rows are accepted → all outputs 0 immediately. After release, a fresh start runs a clean 8-row session with row_idx restarting at 0.
